note_recorder: RTL and testbench

Record/playback stage for the seven piano note switches. It sits between the raw switch inputs and the LED and per-note sound stages, and replaces the switch vector on that path. In pass-through it forwards the live switches. In record mode it also stores each held note pattern with its duration. In playback it replays the stored patterns so the downstream LEDs and sound generators sound the captured performance.

---
 rtl/note_recorder.sv | 222 ++++++++++++++++++++++
 tb/tb_note_recorder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// note_recorder
//   Record/playback stage for the seven piano note switches. Sits between the
//   raw switches and the LED / per-note sound stages. In IDLE and RECORD it
//   forwards the synchronized switches. RECORD also stores each held pattern
//   with its duration in ticks. PLAY replays the stored patterns.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous active-low reset
//     note_in    raw note switches, bit 6 = A .. bit 0 = G, 1 = pressed
//     rec_btn    raw active-low pushbutton, press toggles recording
//     play_btn   raw active-low pushbutton, press starts playback
//     note_out   registered note vector to LED and sound stages
//     recording  high in RECORD
//     playing    high in PLAY
//     full       buffer holds DEPTH entries
//     count      number of stored entries
//
//   Build option NOTE_RECORDER_LOOP_EN: when defined, playback wraps from the
//   last entry back to entry 0, and a play press in PLAY stops playback.
//
//   state  | meaning
//   IDLE   | live pass-through, waiting for a rec or play press
//   RECORD | live pass-through, storing {note, dur} entries
//   PLAY   | replaying stored entries, one tick-timed entry at a time
module note_recorder #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 100,
   parameter int DEPTH   = 32,
   parameter int DUR_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [6:0]                 note_in,
   input  logic                       rec_btn,
   input  logic                       play_btn,
   output logic [6:0]                 note_out,
   output logic                       recording,
   output logic                       playing,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int CNT_W    = $clog2(DEPTH + 1);
   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TICK_DIV = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DUR_W-1:0] DUR_MAX  = '1;
   localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [6:0]       note_s1_q, note_s2_q;
   logic             rec_s1_q, rec_s2_q, rec_s3_q;
   logic             play_s1_q, play_s2_q, play_s3_q;
   logic [PRE_W-1:0] presc_q, presc_d;
   logic [6:0]       note_out_q, note_out_d;
   logic [6:0]       cur_note_q, cur_note_d;
   logic [DUR_W-1:0] dur_cnt_q, dur_cnt_d;
   logic [DUR_W-1:0] remain_q, remain_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic [6+DUR_W:0] mem_q [DEPTH];
   logic             wr_en;
   logic [6+DUR_W:0] wr_data;
   logic             rec_press, play_press, tick, last_entry;

   // Button synchronizers reset to the released (high) level so that reset
   // release can never look like a press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         note_s1_q <= '0;
         note_s2_q <= '0;
         rec_s1_q  <= 1'b1;
         rec_s2_q  <= 1'b1;
         rec_s3_q  <= 1'b1;
         play_s1_q <= 1'b1;
         play_s2_q <= 1'b1;
         play_s3_q <= 1'b1;
      end else begin
         note_s1_q <= note_in;
         note_s2_q <= note_s1_q;
         rec_s1_q  <= rec_btn;
         rec_s2_q  <= rec_s1_q;
         rec_s3_q  <= rec_s2_q;
         play_s1_q <= play_btn;
         play_s2_q <= play_s1_q;
         play_s3_q <= play_s2_q;
      end
   end

   assign rec_press  = rec_s3_q & ~rec_s2_q;
   assign play_press = play_s3_q & ~play_s2_q;

   // Prescaler: down-counter, tick on terminal count 0, reload TICK_DIV-1.
   assign tick    = (presc_q == '0);
   assign presc_d = tick ? PRE_W'(TICK_DIV - 1) : presc_q - 1'b1;

   assign last_entry = (CNT_W'(rd_ptr_q) == count_q - 1'b1);

   always_comb begin
      state_d    = state_q;
      note_out_d = note_s2_q;
      cur_note_d = cur_note_q;
      dur_cnt_d  = dur_cnt_q;
      remain_d   = remain_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      full_d     = full_q;
      wr_en      = 1'b0;
      wr_data    = {cur_note_q, dur_cnt_q};
      unique case (state_q)
         IDLE: begin
            if (rec_press) begin
               state_d    = RECORD;
               count_d    = '0;
               full_d     = 1'b0;
               cur_note_d = note_s2_q;
               dur_cnt_d  = DUR_ONE;
            end else if (play_press && count_q != '0) begin
               state_d  = PLAY;
               rd_ptr_d = PTR_ZERO;
               remain_d = mem_q[PTR_ZERO][DUR_W-1:0];
            end
         end
         RECORD: begin
            if (rec_press) begin
               wr_en   = (count_q < CNT_W'(DEPTH));
               state_d = IDLE;
            end else if (note_s2_q != cur_note_q) begin
               // A tick in the same cycle is dropped: the old note keeps its
               // pre-tick duration and the new note starts at 1.
               wr_en      = 1'b1;
               cur_note_d = note_s2_q;
               dur_cnt_d  = DUR_ONE;
            end else if (tick) begin
               if (dur_cnt_q == DUR_MAX) begin
                  wr_en     = 1'b1;
                  dur_cnt_d = DUR_ONE;
               end else begin
                  dur_cnt_d = dur_cnt_q + 1'b1;
               end
            end
            if (wr_en) begin
               count_d = count_q + 1'b1;
               if (count_d == CNT_W'(DEPTH)) begin
                  full_d  = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         PLAY: begin
            note_out_d = mem_q[rd_ptr_q][6+DUR_W:DUR_W];
            if (rec_press) begin
               state_d = IDLE;
`ifdef NOTE_RECORDER_LOOP_EN
            end else if (play_press) begin
               state_d = IDLE;
`endif
            end else if (tick) begin
               if (remain_q == DUR_ONE) begin
                  if (last_entry) begin
`ifdef NOTE_RECORDER_LOOP_EN
                     rd_ptr_d = PTR_ZERO;
                     remain_d = mem_q[PTR_ZERO][DUR_W-1:0];
`else
                     state_d = IDLE;
`endif
                  end else begin
                     rd_ptr_d = rd_ptr_q + 1'b1;
                     remain_d = mem_q[rd_ptr_q + 1'b1][DUR_W-1:0];
                  end
               end else begin
                  remain_d = remain_q - 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         presc_q    <= '0;
         note_out_q <= '0;
         cur_note_q <= '0;
         dur_cnt_q  <= '0;
         remain_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         note_out_q <= note_out_d;
         cur_note_q <= cur_note_d;
         dur_cnt_q  <= dur_cnt_d;
         remain_q   <= remain_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         full_q     <= full_d;
      end
   end

   // Entry storage has no reset; contents are meaningless until rewritten.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[count_q[PTR_W-1:0]] <= wr_data;
   end

   assign note_out  = note_out_q;
   assign recording = (state_q == RECORD);
   assign playing   = (state_q == PLAY);
   assign full      = full_q;
   assign count     = count_q;
endmodule

// File: tb/tb_note_recorder.sv
module tb_note_recorder;
   localparam int DEPTH = 4;
   localparam int DUR_W = 4;
   localparam int DIV   = 10;
   localparam int DMAX  = 15;
   localparam int M_IDLE = 0, M_REC = 1, M_PLAY = 2;
   localparam logic [6:0] N_A = 7'b1000000, N_B = 7'b0100000, N_G = 7'b0000001;
   localparam logic [6:0] N_LIVE = 7'b0000100;

   logic       clk, rst, rec_btn, play_btn, recording, playing, full;
   logic [6:0] note_in, note_out;
   logic [2:0] count;

   int n_vec = 0;
   int n_err = 0;

   note_recorder #(.CLK_HZ(1000), .TICK_HZ(100), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
      .clk(clk), .rst(rst), .note_in(note_in), .rec_btn(rec_btn), .play_btn(play_btn),
      .note_out(note_out), .recording(recording), .playing(playing), .full(full), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: stored performance as queues of (note, ticks),
   // inputs seen through a two-stage delay, tick every DIV clocks.
   int         m_cyc, m_mode, m_dur, m_idx, m_rem;
   logic [6:0] m_s1, m_s2, m_cur, m_nout;
   logic       m_r1, m_r2, m_r3, m_p1, m_p2, m_p3, rp, pp, tk;
   logic [6:0] q_note[$];
   int         q_dur[$];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cyc = 0; m_mode = M_IDLE; m_dur = 0; m_idx = 0; m_rem = 0;
         m_s1 = '0; m_s2 = '0; m_cur = '0; m_nout = '0;
         m_r1 = 1; m_r2 = 1; m_r3 = 1; m_p1 = 1; m_p2 = 1; m_p3 = 1;
         q_note.delete(); q_dur.delete();
      end else begin
         rp = m_r3 & ~m_r2;
         pp = m_p3 & ~m_p2;
         tk = (m_cyc % DIV == 0);
         m_cyc++;
         m_nout = (m_mode == M_PLAY) ? q_note[m_idx] : m_s2;
         case (m_mode)
            M_IDLE: begin
               if (rp) begin
                  m_mode = M_REC; q_note.delete(); q_dur.delete();
                  m_cur = m_s2; m_dur = 1;
               end else if (pp && q_note.size() > 0) begin
                  m_mode = M_PLAY; m_idx = 0; m_rem = q_dur[0];
               end
            end
            M_REC: begin
               if (rp) begin
                  if (q_note.size() < DEPTH) begin q_note.push_back(m_cur); q_dur.push_back(m_dur); end
                  m_mode = M_IDLE;
               end else if (m_s2 != m_cur) begin
                  q_note.push_back(m_cur); q_dur.push_back(m_dur);
                  m_cur = m_s2; m_dur = 1;
               end else if (tk) begin
                  if (m_dur == DMAX) begin
                     q_note.push_back(m_cur); q_dur.push_back(DMAX); m_dur = 1;
                  end else m_dur++;
               end
               if (q_note.size() == DEPTH) m_mode = M_IDLE;
            end
            default: begin
               if (rp) m_mode = M_IDLE;
`ifdef NOTE_RECORDER_LOOP_EN
               else if (pp) m_mode = M_IDLE;
`endif
               else if (tk) begin
                  m_rem--;
                  if (m_rem == 0) begin
                     if (m_idx == q_note.size() - 1) begin
`ifdef NOTE_RECORDER_LOOP_EN
                        m_idx = 0; m_rem = q_dur[0];
`else
                        m_mode = M_IDLE;
`endif
                     end else begin
                        m_idx++; m_rem = q_dur[m_idx];
                     end
                  end
               end
            end
         endcase
         m_r3 = m_r2; m_r2 = m_r1; m_r1 = rec_btn;
         m_p3 = m_p2; m_p2 = m_p1; m_p1 = play_btn;
         m_s2 = m_s1; m_s1 = note_in;
      end
   end

   always @(negedge clk) begin
      n_vec++;
      if (note_out !== m_nout || recording !== (m_mode == M_REC) || playing !== (m_mode == M_PLAY)
          || full !== (q_note.size() == DEPTH) || count !== 3'(q_note.size())) begin
         n_err++;
         $display("FAIL cycle_cmp t=%0t: note_out=%b rec=%b play=%b full=%b count=%0d, required note_out=%b rec=%b play=%b full=%b count=%0d",
                  $time, note_out, recording, playing, full, count, m_nout, m_mode == M_REC,
                  m_mode == M_PLAY, q_note.size() == DEPTH, q_note.size());
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit r, input bit p);
      rec_btn = ~r; play_btn = ~p;
      @(negedge clk);
      rec_btn = 1'b1; play_btn = 1'b1;
   endtask

   task automatic align3();
      while (m_cyc % DIV != 3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nz, nl, to;
      logic [6:0] prev;
      rst = 1'b0; note_in = '0; rec_btn = 1'b1; play_btn = 1'b1;
      step(3);
      chk("rst_note_out", note_out, 0);
      chk("rst_recording", recording, 0);
      chk("rst_playing", playing, 0);
      chk("rst_full", full, 0);
      chk("rst_count", count, 0);
      rst = 1'b1;
      step(4);

      press(0, 1); step(5);
      chk("play_empty_ignored", playing, 0);

      // Long A then short G: 30 ticks of A splits at the 15-tick maximum.
      note_in = N_A; step(5); align3();
      press(1, 0);
      step(4);
      chk("rec_entered", recording, 1);
      step(295);
      note_in = N_G; step(25);
      press(1, 0); step(5);
      chk("rec4_count", count, 4);
      chk("rec4_full", full, 1);
      chk("rec4_idle", recording, 0);
      chk("rec4_size", q_note.size(), 4);
      chk("rec4_e0", {q_note[0], 4'(q_dur[0])}, {N_A, 4'd15});
      chk("rec4_e1", {q_note[1], 4'(q_dur[1])}, {N_A, 4'd15});
      chk("rec4_e2", {q_note[2], 4'(q_dur[2])}, {N_A, 4'd1});
      chk("rec4_e3", {q_note[3], 4'(q_dur[3])}, {N_G, 4'd3});

      // Record {B,5}, {0,2}.
      note_in = N_B; step(5); align3();
      press(1, 0); step(39);
      note_in = 7'b0; step(10);
      press(1, 0); step(5);
      chk("rec2_count", count, 2);
      chk("rec2_full", full, 0);
      chk("rec2_e0", {q_note[0], 4'(q_dur[0])}, {N_B, 4'd5});
      chk("rec2_e1", {q_note[1], 4'(q_dur[1])}, {7'b0, 4'd2});

      note_in = N_LIVE; step(5);
`ifdef NOTE_RECORDER_LOOP_EN
      press(0, 1);
      prev = note_out; nl = 0;
      for (int i = 0; i < 260; i++) begin
         @(negedge clk);
         if (playing && prev == 7'b0 && note_out == N_B) nl++;
         prev = note_out;
      end
      chk("loop_count_ge3", nl >= 3, 1);
      press(0, 1); step(3);
      chk("loop_play_stops", playing, 0);
      step(3);
`else
      press(0, 1);
      nb = 0; nz = 0; to = 0;
      while (!playing && to < 10) begin @(negedge clk); to++; end
      chk("play_started", playing, 1);
      to = 0;
      while (playing && to < 200) begin
         if (note_out == N_B) nb++;
         if (note_out == 7'b0) nz++;
         @(negedge clk); to++;
      end
      chk("play_ended", playing, 0);
      chk("play_b_len_41_50", (nb >= 41 && nb <= 50), 1);
      chk("play_rest_len", nz, 19);
      step(1);
      chk("play_back_to_live", note_out, N_LIVE);
      step(3);
`endif

      // Abort PLAY with rec, then replay from entry 0.
      press(0, 1); step(20);
      press(1, 0); step(3);
      chk("abort_playing", playing, 0);
      chk("abort_count", count, 2);
      press(0, 1); step(2);
      chk("replay_playing", playing, 1);
      step(1);
      chk("replay_entry0", note_out, N_B);
      press(1, 0); step(5);

      press(1, 1); step(3);
      chk("simul_recording", recording, 1);
      chk("simul_playing", playing, 0);
      press(1, 0); step(5);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) note_in = 7'($urandom_range(0, 127));
         rec_btn  = ($urandom_range(0, 249) != 0);
         play_btn = ($urandom_range(0, 149) != 0);
         @(negedge clk);
      end
      rec_btn = 1'b1; play_btn = 1'b1; step(10);
      for (int t = 0; t < 4 && m_mode != M_IDLE; t++) begin press(1, 0); step(5); end

      // Reset in the middle of playback.
      note_in = N_A; step(3);
      press(1, 0); step(30);
      press(1, 0); step(5);
      press(0, 1); step(10);
      chk("pre_reset_playing", playing, 1);
      @(negedge clk); #2 rst = 1'b0;
      note_in = 7'b0;
      @(negedge clk);
      chk("mid_rst_note_out", note_out, 0);
      chk("mid_rst_playing", playing, 0);
      chk("mid_rst_recording", recording, 0);
      chk("mid_rst_full", full, 0);
      chk("mid_rst_count", count, 0);
      step(2); rst = 1'b1; step(2);
      note_in = N_A; step(2);
      chk("passthru_not_yet", note_out, 0);
      step(1);
      chk("passthru_3clk", note_out, N_A);
      step(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
